// File: rtl/rvv_backend_rs_credit_pkg.sv
// rtl/rvv_backend_rs_credit_pkg.sv - shared constants for the RS credit controllers
package rvv_backend_rs_credit_pkg;

  localparam int NUM_DP_UOP      = 2;
  localparam int ALU_RS_DEPTH    = 8;
  localparam int PMTRDT_RS_DEPTH = 8;
  localparam int MUL_RS_DEPTH    = 8;
  localparam int DIV_RS_DEPTH    = 8;
  localparam int LSU_RS_DEPTH    = 8;

  typedef logic [0:0] rs_credit_state_t;

  localparam rs_credit_state_t ST_RUN   = 1'b0;
  localparam rs_credit_state_t ST_FLUSH = 1'b1;

endpackage

// File: rtl/rvv_backend_rs_credit_if.sv
// rtl/rvv_backend_rs_credit_if.sv - dispatch/RS bundle seen by one RS credit controller
interface rvv_backend_rs_credit_if #(
  parameter int NUM_DP  = 2,
  parameter int NUM_RET = 2,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = $clog2(DEPTH + 1)
);

  logic [NUM_DP-1:0]  uop_req;
  logic [NUM_DP-1:0]  rs_valid;
  logic [NUM_DP-1:0]  rs_ready;
  logic [NUM_RET-1:0] pop_valid;
  logic               flush;
  logic [CNT_W-1:0]   credit_cnt;
  logic               rs_full;
  logic               rs_empty;
  logic               err_protocol;

  modport master (
    output uop_req, rs_valid, pop_valid, flush,
    input  rs_ready, credit_cnt, rs_full, rs_empty, err_protocol
  );

  modport slave (
    input  uop_req, rs_valid, pop_valid, flush,
    output rs_ready, credit_cnt, rs_full, rs_empty, err_protocol
  );

endinterface

// File: rtl/rvv_backend_popcnt.sv
// rtl/rvv_backend_popcnt.sv - combinational population count with caller-chosen result width
module rvv_backend_popcnt #(
  parameter int W     = 2,
  parameter int OUT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     bits_i,
  output logic [OUT_W-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int k = 0; k < W; k++) begin
      cnt_o = cnt_o + OUT_W'(bits_i[k]);
    end
  end

endmodule

// File: rtl/rvv_backend_rs_credit.sv
// rtl/rvv_backend_rs_credit.sv - free-entry credit tracker and per-slot ready generator for one RS
module rvv_backend_rs_credit
  import rvv_backend_rs_credit_pkg::*;
#(
  parameter int NUM_DP  = NUM_DP_UOP,
  parameter int NUM_RET = 2,
  parameter int DEPTH   = ALU_RS_DEPTH
) (
  input logic                    clk,
  input logic                    rst,
  rvv_backend_rs_credit_if.slave rs_if
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int CW1   = CNT_W + 1;

  rs_credit_state_t state_q, state_d;
  logic [CNT_W-1:0] credit_q, credit_d;
  logic             err_q, err_d;

  logic [CW1-1:0]    prefix [NUM_DP];
  logic [NUM_DP-1:0] ready;
  logic [NUM_DP-1:0] acc;
  logic [CW1-1:0]    push_cnt;
  logic [CW1-1:0]    pop_cnt;
  logic [CW1-1:0]    next_w;
  logic              overflow;
  logic              bad_push;

  // Slot i needs one free entry beyond every lower-numbered request this cycle.
  assign prefix[0] = '0;
  for (genvar i = 1; i < NUM_DP; i++) begin : g_prefix
    rvv_backend_popcnt #(.W(i), .OUT_W(CW1)) u_prefix (
      .bits_i (rs_if.uop_req[i-1:0]),
      .cnt_o  (prefix[i])
    );
  end

  always_comb begin
    ready = '0;
    for (int i = 0; i < NUM_DP; i++) begin
      ready[i] = (state_q == ST_RUN) && !rs_if.flush && rs_if.uop_req[i] &&
                 ({1'b0, credit_q} > prefix[i]);
    end
  end

  assign acc      = rs_if.rs_valid & ready;
  assign bad_push = |(rs_if.rs_valid & ~ready);

  rvv_backend_popcnt #(.W(NUM_DP), .OUT_W(CW1)) u_push_cnt (
    .bits_i (acc),
    .cnt_o  (push_cnt)
  );

  rvv_backend_popcnt #(.W(NUM_RET), .OUT_W(CW1)) u_pop_cnt (
    .bits_i (rs_if.pop_valid),
    .cnt_o  (pop_cnt)
  );

  // Accepted pushes never exceed credit_q, so only the return side can leave range.
  assign next_w   = {1'b0, credit_q} - push_cnt + pop_cnt;
  assign overflow = next_w > CW1'(DEPTH);

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    err_d    = err_q;
    case (state_q)
      ST_RUN: begin
        if (rs_if.flush) begin
          state_d  = ST_FLUSH;
          credit_d = CNT_W'(DEPTH);
        end else begin
          credit_d = overflow ? CNT_W'(DEPTH) : next_w[CNT_W-1:0];
          if (bad_push || overflow) begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        credit_d = CNT_W'(DEPTH);
        if (!rs_if.flush) begin
          state_d = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      credit_q <= CNT_W'(DEPTH);
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  assign rs_if.rs_ready     = ready;
  assign rs_if.credit_cnt   = credit_q;
  assign rs_if.rs_full      = (credit_q == '0);
  assign rs_if.rs_empty     = (credit_q == CNT_W'(DEPTH));
  assign rs_if.err_protocol = err_q;

endmodule

// File: tb/tb_rvv_backend_rs_credit.sv
// tb/tb_rvv_backend_rs_credit.sv - self-checking bench for the RS credit controller
module tb_rvv_backend_rs_credit;

  localparam int NUM_DP  = 2;
  localparam int NUM_RET = 2;
  localparam int DEPTH   = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rvv_backend_rs_credit_if #(.NUM_DP(NUM_DP), .NUM_RET(NUM_RET), .DEPTH(DEPTH)) rs_if ();

  rvv_backend_rs_credit #(.NUM_DP(NUM_DP), .NUM_RET(NUM_RET), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .rs_if (rs_if)
  );

  int total = 0;
  int bad   = 0;

  // Reference: free-entry count, whether dispatch is live, sticky error.
  int m_credit;
  bit m_run;
  bit m_err;

  function automatic logic [1:0] m_ready(input logic [1:0] u, input logic f);
    int seen;
    logic [1:0] r;
    seen = 0;
    r    = '0;
    if (m_run && !f) begin
      for (int i = 0; i < NUM_DP; i++) begin
        if (u[i]) begin
          if (m_credit > seen) r[i] = 1'b1;
          seen++;
        end
      end
    end
    return r;
  endfunction

  task automatic set_in(input logic [1:0] u, input logic [1:0] v, input logic [1:0] p,
                        input logic f);
    rs_if.uop_req   = u;
    rs_if.rs_valid  = v;
    rs_if.pop_valid = p;
    rs_if.flush     = f;
  endtask

  task automatic step();
    logic [1:0] r;
    int n;
    r = m_ready(rs_if.uop_req, rs_if.flush);
    @(posedge clk);
    if (rst) begin
      m_credit = DEPTH; m_run = 1'b1; m_err = 1'b0;
    end else if (!m_run) begin
      m_credit = DEPTH; m_run = !rs_if.flush;
    end else if (rs_if.flush) begin
      m_credit = DEPTH; m_run = 1'b0;
    end else begin
      if ((rs_if.rs_valid & ~r) != 2'b00) m_err = 1'b1;
      n = m_credit - $countones(rs_if.rs_valid & r) + $countones(rs_if.pop_valid);
      if (n > DEPTH) begin
        m_err = 1'b1;
        n = DEPTH;
      end
      m_credit = n;
    end
    #2;
    total++;
    if (rs_if.credit_cnt > DEPTH) begin
      bad++;
      $display("FAIL range credit_cnt=%0d exceeds %0d (underflow wrap)", rs_if.credit_cnt, DEPTH);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(2'b00, 2'b00, 2'b00, 1'b0);
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic goto_credit(input int c);
    do_reset();
    for (int k = 0; k < DEPTH && m_credit > c; k++) begin
      if (m_credit - c >= 2) set_in(2'b11, 2'b11, 2'b00, 1'b0);
      else                   set_in(2'b01, 2'b01, 2'b00, 1'b0);
      step();
    end
    set_in(2'b00, 2'b00, 2'b00, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    set_in(2'b11, 2'b00, 2'b00, 1'b0);
    #1;
    total++; if (rs_if.credit_cnt !== 4'd8) begin bad++; $display("FAIL reset_credit got=%0d exp=8", rs_if.credit_cnt); end
    total++; if (rs_if.rs_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", rs_if.rs_empty); end
    total++; if (rs_if.rs_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", rs_if.rs_full); end
    total++; if (rs_if.err_protocol !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", rs_if.err_protocol); end
    total++; if (rs_if.rs_ready !== 2'b11) begin bad++; $display("FAIL reset_ready got=%b exp=11", rs_if.rs_ready); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_in(2'b11, 2'b11, 2'b00, 1'b0);
      #1;
      total++; if (rs_if.rs_ready !== 2'b11) begin bad++; $display("FAIL fill_ready[%0d] got=%b exp=11", k, rs_if.rs_ready); end
      step();
      total++; if (rs_if.credit_cnt !== 4'(6 - 2 * k)) begin bad++; $display("FAIL fill_credit[%0d] got=%0d exp=%0d", k, rs_if.credit_cnt, 6 - 2 * k); end
    end
    set_in(2'b11, 2'b00, 2'b00, 1'b0);
    #1;
    total++; if (rs_if.rs_full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", rs_if.rs_full); end
    total++; if (rs_if.rs_ready !== 2'b00) begin bad++; $display("FAIL fill_ready_zero got=%b exp=00", rs_if.rs_ready); end
    total++; if (rs_if.err_protocol !== 1'b0) begin bad++; $display("FAIL fill_err got=%b exp=0", rs_if.err_protocol); end
  endtask

  task automatic test_last_credit();
    goto_credit(1);
    set_in(2'b10, 2'b10, 2'b00, 1'b0);
    #1;
    total++; if (rs_if.rs_ready !== 2'b10) begin bad++; $display("FAIL one_ready_10 got=%b exp=10", rs_if.rs_ready); end
    step();
    total++; if (rs_if.credit_cnt !== 4'd0) begin bad++; $display("FAIL one_credit got=%0d exp=0", rs_if.credit_cnt); end
    goto_credit(1);
    set_in(2'b11, 2'b00, 2'b00, 1'b0);
    #1;
    total++; if (rs_if.rs_ready !== 2'b01) begin bad++; $display("FAIL one_ready_11 got=%b exp=01", rs_if.rs_ready); end
  endtask

  task automatic test_push_pop();
    goto_credit(3);
    set_in(2'b11, 2'b11, 2'b11, 1'b0);
    step();
    total++; if (rs_if.credit_cnt !== 4'd3) begin bad++; $display("FAIL pp_same got=%0d exp=3", rs_if.credit_cnt); end
    set_in(2'b00, 2'b00, 2'b11, 1'b0);
    #1;
    total++; if (rs_if.credit_cnt !== 4'd3) begin bad++; $display("FAIL pp_pop_latency got=%0d exp=3", rs_if.credit_cnt); end
    step();
    total++; if (rs_if.credit_cnt !== 4'd5) begin bad++; $display("FAIL pp_pop_only got=%0d exp=5", rs_if.credit_cnt); end
    total++; if (rs_if.err_protocol !== 1'b0) begin bad++; $display("FAIL pp_err got=%b exp=0", rs_if.err_protocol); end
  endtask

  task automatic test_flush();
    goto_credit(2);
    set_in(2'b11, 2'b11, 2'b11, 1'b1);
    #1;
    total++; if (rs_if.rs_ready !== 2'b00) begin bad++; $display("FAIL flush_ready_c0 got=%b exp=00", rs_if.rs_ready); end
    step();
    total++; if (rs_if.rs_ready !== 2'b00) begin bad++; $display("FAIL flush_ready_c1 got=%b exp=00", rs_if.rs_ready); end
    step();
    set_in(2'b11, 2'b11, 2'b11, 1'b0);
    #1;
    total++; if (rs_if.rs_ready !== 2'b00) begin bad++; $display("FAIL flush_ready_drop got=%b exp=00", rs_if.rs_ready); end
    total++; if (rs_if.credit_cnt !== 4'd8) begin bad++; $display("FAIL flush_credit got=%0d exp=8", rs_if.credit_cnt); end
    step();
    set_in(2'b11, 2'b00, 2'b00, 1'b0);
    #1;
    total++; if (rs_if.rs_ready !== 2'b11) begin bad++; $display("FAIL flush_ready_back got=%b exp=11", rs_if.rs_ready); end
    total++; if (rs_if.credit_cnt !== 4'd8) begin bad++; $display("FAIL flush_credit_after got=%0d exp=8", rs_if.credit_cnt); end
    total++; if (rs_if.err_protocol !== 1'b0) begin bad++; $display("FAIL flush_err got=%b exp=0", rs_if.err_protocol); end
  endtask

  task automatic test_errors();
    goto_credit(0);
    set_in(2'b01, 2'b01, 2'b00, 1'b0);
    step();
    total++; if (rs_if.err_protocol !== 1'b1) begin bad++; $display("FAIL err_push got=%b exp=1", rs_if.err_protocol); end
    total++; if (rs_if.credit_cnt !== 4'd0) begin bad++; $display("FAIL err_push_credit got=%0d exp=0", rs_if.credit_cnt); end
    goto_credit(7);
    total++; if (rs_if.err_protocol !== 1'b0) begin bad++; $display("FAIL err_rst_clear got=%b exp=0", rs_if.err_protocol); end
    set_in(2'b00, 2'b00, 2'b11, 1'b0);
    step();
    total++; if (rs_if.credit_cnt !== 4'd8) begin bad++; $display("FAIL err_ovf_credit got=%0d exp=8", rs_if.credit_cnt); end
    total++; if (rs_if.err_protocol !== 1'b1) begin bad++; $display("FAIL err_ovf got=%b exp=1", rs_if.err_protocol); end
    set_in(2'b00, 2'b00, 2'b00, 1'b1);
    step();
    set_in(2'b00, 2'b00, 2'b00, 1'b0);
    step();
    step();
    total++; if (rs_if.err_protocol !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", rs_if.err_protocol); end
  endtask

  task automatic test_random();
    logic [1:0] u, v, p, r;
    logic f;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 63) == 0);
      u = 2'($urandom);
      v = ($urandom_range(0, 7) == 0) ? 2'($urandom) : (u & m_ready(u, 1'b0) & 2'($urandom));
      p = (m_credit < DEPTH - 1 || $urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
      f = ($urandom_range(0, 15) == 0);
      set_in(u, v, p, f);
      #1;
      r = m_ready(u, f);
      total++; if (rs_if.rs_ready !== r) begin bad++; $display("FAIL rand_ready[%0d] got=%b exp=%b", k, rs_if.rs_ready, r); end
      step();
      total++; if (rs_if.credit_cnt !== 4'(m_credit)) begin bad++; $display("FAIL rand_credit[%0d] got=%0d exp=%0d", k, rs_if.credit_cnt, m_credit); end
      total++; if (rs_if.err_protocol !== m_err) begin bad++; $display("FAIL rand_err[%0d] got=%b exp=%b", k, rs_if.err_protocol, m_err); end
      total++; if (rs_if.rs_full !== (m_credit == 0)) begin bad++; $display("FAIL rand_full[%0d] got=%b credit=%0d", k, rs_if.rs_full, m_credit); end
      total++; if (rs_if.rs_empty !== (m_credit == DEPTH)) begin bad++; $display("FAIL rand_empty[%0d] got=%b credit=%0d", k, rs_if.rs_empty, m_credit); end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    m_credit = DEPTH;
    m_run = 1'b1;
    m_err = 1'b0;
    set_in(2'b00, 2'b00, 2'b00, 1'b0);
    test_reset();
    test_fill();
    test_last_credit();
    test_push_pop();
    test_flush();
    test_errors();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rvv_backend_rs_credit.md
Name: rvv_backend_rs_credit

Overview:
- Per-reservation-station credit controller.
- One instance sits beside each RS (ALU, PMTRDT, MUL, DIV, LSU). It tracks free RS entries and produces that RS's per-slot ready vector for the dispatch controller.
- Dispatch pushes consume credits; RS issue pops return them.
- Flush restores full capacity.

Parameters:
- NUM_DP, 2 (tie to `NUM_DP_UOP`): dispatch slots per cycle.
- NUM_RET, 2: max RS pops (credit returns) per cycle.
- DEPTH, 8: RS entry count; must be ≥ NUM_DP.
- CNT_W, $clog2(DEPTH+1): credit counter width (derived, not overridden).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- uop_req  input  NUM_DP  slot i targets this RS; decoded from uop_ctrl exe_unit and independent of ready
- rs_valid  input  NUM_DP  push handshake from dispatch, e.g. rs_valid_dp2alu
- rs_ready  output  NUM_DP  per-slot ready to dispatch, e.g. rs_ready_alu2dp
- pop_valid  input  NUM_RET  entry j leaves RS this cycle
- flush  input  1  trap/kill; RS contents discarded
- credit_cnt  output  CNT_W  current free entries
- rs_full  output  1  credit_cnt==0
- rs_empty  output  1  credit_cnt==DEPTH
- err_protocol  output  1  sticky protocol-violation flag

Behaviour:
- Reset:
  - credit_cnt=DEPTH, state=RUN, err_protocol=0.
  - Outputs in the cycle after rst: rs_ready all 1 (DEPTH≥NUM_DP), rs_full=0, rs_empty=1.
  - rst mid-operation overrides flush, pushes and pops.
- FSM states: RUN, FLUSH.
  - RUN→FLUSH when flush=1.
  - FLUSH→RUN on the first cycle flush=0.
  - In FLUSH: rs_ready=0; credit_cnt loads DEPTH every cycle; rs_valid and pop_valid are ignored and do not set err.
  - flush in RUN: the same-cycle rs_valid and pop_valid are discarded, credit_cnt=DEPTH next cycle, and rs_ready is already forced 0 that cycle.
- Ready generation:
  - Combinational from registered credit_cnt and uop_req only; no path from rs_valid, so no loop with dispatch.
  - rs_ready[i] = state==RUN && uop_req[i] && credit_cnt > popcount(uop_req[i-1:0]).
  - Slot 0 compares against 0.
  - Non-requesting slots read 0.
- Accepted pushes: acc[i] = rs_valid[i] & rs_ready[i].
- Counter update (RUN, no flush): next = credit_cnt - popcount(acc) + popcount(pop_valid), computed at CNT_W+1 bits.
  - Same-cycle push and pop both apply.
  - Pop is credited the next cycle, not the same cycle.
- Protocol errors: set err_protocol, which stays set until rst. Cases:
  - rs_valid[i] & ~rs_ready[i]. The push is not counted.
  - Return overflow, next > DEPTH. credit_cnt saturates at DEPTH.
  - Underflow is impossible by construction. Assert it in the bench.
- Latency: credit change is visible on rs_ready one cycle after the push or pop edge.
- Boundaries:
  - credit_cnt=0: rs_ready=0, rs_full=1.
  - Full RS with pops only: credits rise by popcount, saturating at DEPTH.
  - credit_cnt=1 with uop_req=2'b11: only slot 0 is ready.

Decomposition:
- Shared package (rvv_backend.svh / rvv_backend_dispatch.svh):
  - RS_CREDIT_STATE_e {RUN, FLUSH}
  - per-RS depth constants (`ALU_RS_DEPTH` etc.)
- A small rvv_backend_popcnt sub-module (parameterised width, combinational) is natural. It is reused for the prefix counts and for the push/pop sums.

Test Plan:
- Reset, DEPTH=8 → credit_cnt=8, rs_empty=1, rs_ready=2'b11 when uop_req=2'b11.
- 4 cycles of uop_req=rs_valid=2'b11, no pops → credit_cnt 8→6→4→2→0. Then rs_full=1 and rs_ready=0. err_protocol stays 0.
- credit_cnt=1, uop_req=2'b10 → rs_ready=2'b10, slot 1 accepted, credit_cnt=0 next cycle. With uop_req=2'b11 → rs_ready=2'b01.
- credit_cnt=3, push 2 and pop 2 in the same cycle → credit_cnt=3. Push 0, pop 2 → credit_cnt=5.
- credit_cnt=2, flush for 2 cycles with rs_valid=2'b11 and pop_valid=2'b11 → rs_ready=0 while in FLUSH. credit_cnt=8 after, err_protocol=0. Ready returns the cycle after flush drops.
- Errors:
  - rs_valid=2'b01 while credit_cnt=0 → err_protocol=1 and credit_cnt stays 0.
  - Separately, credit_cnt=7 with pop_valid=2'b11 → credit_cnt=8 (saturated) and err_protocol=1.
  - Only rst clears err_protocol.
